// File: rtl/reg_write_decoder.sv
// reg_write_decoder: Avalon-MM write decoder with byte-lane merge and 2-entry command queue
module reg_write_decoder #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               write,
  input  logic [WIDTH-1:0]   writedata,
  input  logic [WIDTH/8-1:0] byteenable,
  output logic               waitrequest,
  output logic [WIDTH-1:0]   reg1Data,
  output logic [WIDTH-1:0]   reg2Data,
  output logic               cmd_valid,
  output logic               cmd_reg,
  output logic [WIDTH-1:0]   cmd_data,
  input  logic               cmd_ready
);
  logic [WIDTH-1:0] reg1_q, reg1_d, reg2_q, reg2_d, d0_q, d0_d, d1_q, d1_d, old, merged;
  logic [1:0] count_q, count_d;
  logic r0_q, r0_d, r1_q, r1_d, sel1, sel2, push, pop, lvl0;
  // Merge the incoming byte lanes over the currently held value of the target register
  always_comb begin
    sel1 = address == 3'b001;
    sel2 = address == 3'b100;
    old = sel2 ? reg2_q : reg1_q;
    merged = old;
    for (int i = 0; i < WIDTH/8; i++) merged[8*i+:8] = byteenable[i] ? writedata[8*i+:8] : old[8*i+:8];
  end
  // Next state: register update, queue push into first free slot after any pop, head shift on pop
  always_comb begin
    push = write && count_q != 2'd2 && (sel1 || sel2);
    pop = count_q != 2'd0 && cmd_ready;
    lvl0 = pop ? count_q == 2'd1 : count_q == 2'd0;
    reg1_d = push && sel1 ? merged : reg1_q;
    reg2_d = push && sel2 ? merged : reg2_q;
    r0_d = push && lvl0 ? sel2 : pop ? r1_q : r0_q;
    d0_d = push && lvl0 ? merged : pop ? d1_q : d0_q;
    r1_d = push && !lvl0 ? sel2 : r1_q;
    d1_d = push && !lvl0 ? merged : d1_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg1_q <= '0;
      reg2_q <= '0;
      r0_q <= 1'b0;
      r1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
      count_q <= 2'd0;
    end else begin
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      r0_q <= r0_d;
      r1_q <= r1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      count_q <= count_d;
    end
  end
  assign waitrequest = count_q == 2'd2;
  assign cmd_valid = count_q != 2'd0;
  assign cmd_reg = r0_q;
  assign cmd_data = d0_q;
  assign reg1Data = reg1_q;
  assign reg2Data = reg2_q;
endmodule

// File: doc/reg_write_decoder.md
# reg_write_decoder

Write-side companion to the read multiplexer on the QSYS register interface: it decodes Avalon-MM writes on the 3-bit register address, merges byte lanes into two WIDTH-bit holding registers, and exposes those registers for read-back. Each accepted write to a valid register also queues a command toward the downstream riser logic. Queuing uses a 2-entry buffer with valid/ready handshake, and backpressure to the bus master is applied via waitrequest.

## Interface
- WIDTH, 32, register/data width; must be a multiple of 8
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  3  register address from QSYS
- write  in  1  write request, qualified by waitrequest
- writedata  in  WIDTH  write data
- byteenable  in  WIDTH/8  per-byte write enable; bit i covers writedata[8i+7:8i]
- waitrequest  out  1  high = write not accepted this cycle
- reg1Data  out  WIDTH  holding register 1 (address 3'b001), feeds read path
- reg2Data  out  WIDTH  holding register 2 (address 3'b100), feeds read path
- cmd_valid  out  1  head of command buffer is valid
- cmd_reg  out  1  head command target: 0 = reg1, 1 = reg2
- cmd_data  out  WIDTH  head command data (merged register value)
- cmd_ready  in  1  downstream accepts head command

## Operation
- Decode: 3'b001 → reg1, 3'b100 → reg2; all other addresses are "invalid".
- Acceptance: a write is accepted on a rising edge when write=1 and waitrequest=0.
- Accepted valid write:
  - New value = old value with bytes replaced where byteenable=1.
  - Register takes the new value; {target, new value} is pushed into the command buffer.
  - byteenable=0 still updates the register (no change) and still pushes a command.
- Accepted invalid write: consumed silently; no register change, no push.
- Command buffer:
  - 2-entry FIFO, states EMPTY (count 0), ONE (1), FULL (2).
  - Pop when cmd_valid=1 and cmd_ready=1 at an edge.
  - Push and pop in the same cycle leave the count unchanged, with order preserved.
- waitrequest = (count==2), independent of address and write. A write attempt while FULL stalls until a pop.
  - In FULL with cmd_ready=1, waitrequest is still 1 that cycle; the pop frees space and the write is accepted the next cycle.
- cmd_valid = (count != 0). cmd_reg/cmd_data show the head entry; they are don't-care when cmd_valid=0 but are driven, never Z.
- Back-to-back partial writes to the same register merge against the value produced by the previous write.

## Timing
- Reset values: reg1Data=0, reg2Data=0, cmd_valid=0, cmd_reg=0, cmd_data=0, waitrequest=0, count=0.
- Reset asserted mid-operation clears the registers and buffer immediately (asynchronous). Pending commands are discarded.
- Write latency:
  - A write accepted at edge N is visible on reg1Data/reg2Data after edge N.
  - If the buffer was EMPTY, cmd_valid rises after edge N with that command at the head.
- Throughput: one write per cycle while the downstream pops every cycle. With cmd_ready held low, at most 2 writes are accepted, then waitrequest=1.
- Pop at edge M: the next entry appears at the head after edge M. If that empties the buffer, cmd_valid falls after M.
- State transitions per edge:
  - push only: count+1
  - pop only: count−1
  - push+pop: unchanged
  - pop from EMPTY: impossible
  - push into FULL: impossible (stalled)
- All outputs are registered or decoded from registered state. No combinational path from cmd_ready or write to waitrequest.

## Test plan
- Reset: assert reset mid-run with 2 queued commands → all outputs 0, cmd_valid=0, waitrequest=0 immediately; the buffer is empty after release.
- Full write: address=3'b001, writedata=32'hDEADBEEF, byteenable=4'hF, cmd_ready=1 → reg1Data=32'hDEADBEEF after the edge; cmd_valid=1, cmd_reg=0, cmd_data=32'hDEADBEEF; popped the next edge.
- Partial merge: reg2Data=32'h11223344, then write address 3'b100, data 32'hAABBCCDD, byteenable=4'b0101 → reg2Data=32'h11BB33DD; cmd_reg=1, cmd_data=32'h11BB33DD.
- Invalid address: write to 3'b010 with data 32'hFFFFFFFF → reg1Data/reg2Data unchanged, no command, waitrequest stays 0.
- Backpressure: cmd_ready=0, three consecutive writes to reg1 (values 1, 2, 3) → first two accepted, waitrequest=1 on the third. Raise cmd_ready → pops in order (1, then 2); value 3 is accepted the cycle after the first pop and reg1Data=3.
- Simultaneous push/pop in ONE state: head=5, cmd_ready=1, write reg2=7 → count remains 1, head becomes {1,7}, no waitrequest.
